// File: rtl/xbar_rsp_rob.sv
// Per-channel response reorder buffer: slots are reserved in order, filled out of
// order by the banks, and drained to the channel strictly in allocation order.
module xbar_rsp_rob #(
  parameter logic [1:0] CH_ID     = 2'd0,
  parameter int         NUM_BANKS = 4,
  parameter int         ROB_AW    = 3,
  parameter int         DATA_W    = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  output logic [ROB_AW-1:0]             alloc_rob_num_o,
  input  logic [NUM_BANKS-1:0]          bank_rsp_valid_i,
  input  logic [2*NUM_BANKS-1:0]        bank_rsp_ch_id_i,
  input  logic [ROB_AW*NUM_BANKS-1:0]   bank_rsp_rob_i,
  input  logic [DATA_W*NUM_BANKS-1:0]   bank_rsp_data_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_W-1:0]             rsp_data_o,
  output logic [ROB_AW-1:0]             rsp_rob_num_o,
  output logic                          rob_pop_o,
  output logic [ROB_AW:0]               rob_count_o,
  output logic                          rob_err_o
);
  localparam int DEPTH = 1 << ROB_AW;
  localparam logic [ROB_AW:0] PTR_ONE = {{ROB_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_FREE, S_PEND, S_FILL} slot_st_e;

  slot_st_e            r_st   [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [ROB_AW:0]     r_head, r_tail, r_count;
  logic                r_err;

  logic [ROB_AW-1:0]   w_head_idx, w_tail_idx;
  logic                w_full, w_rsp_valid, w_alloc_fire, w_pop_fire, w_fill_err;
  logic [NUM_BANKS-1:0] w_hit, w_dup, w_fill_en;
  logic [ROB_AW-1:0]   w_rob [NUM_BANKS];

  assign w_head_idx   = r_head[ROB_AW-1:0];
  assign w_tail_idx   = r_tail[ROB_AW-1:0];
  assign w_full       = (w_head_idx == w_tail_idx) && (r_head[ROB_AW] != r_tail[ROB_AW]);
  assign w_rsp_valid  = (r_st[w_head_idx] == S_FILL);
  // Both fires look only at registered state, so a pop never frees a slot for a same-cycle alloc.
  assign w_alloc_fire = alloc_valid_i && !w_full && !rst_i;
  assign w_pop_fire   = w_rsp_valid && rsp_ready_i && !rst_i;

  always_comb begin
    w_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_rob[b] = bank_rsp_rob_i[b*ROB_AW +: ROB_AW];
      w_hit[b] = bank_rsp_valid_i[b] && (bank_rsp_ch_id_i[b*2 +: 2] == CH_ID) && !rst_i;
    end
  end

  // A bank loses if any lower-numbered bank targets the same slot this cycle.
  always_comb begin
    w_dup = '0;
    for (int b = 1; b < NUM_BANKS; b++)
      for (int c = 0; c < b; c++)
        if (w_hit[b] && w_hit[c] && (w_rob[b] == w_rob[c])) w_dup[b] = 1'b1;
  end

  always_comb begin
    w_fill_en  = '0;
    w_fill_err = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_hit[b]) begin
        if (w_dup[b])                       w_fill_err   = 1'b1;
        else if (r_st[w_rob[b]] == S_PEND)  w_fill_en[b] = 1'b1;
        else                                w_fill_err   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= S_FREE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop_fire)   r_st[w_head_idx] <= S_FREE;
      if (w_alloc_fire) r_st[w_tail_idx] <= S_PEND;
      for (int b = 0; b < NUM_BANKS; b++)
        if (w_fill_en[b]) r_st[w_rob[b]] <= S_FILL;
      if (w_pop_fire)   r_head <= r_head + PTR_ONE;
      if (w_alloc_fire) r_tail <= r_tail + PTR_ONE;
      r_count <= r_count + (ROB_AW+1)'(w_alloc_fire) - (ROB_AW+1)'(w_pop_fire);
      if (w_fill_err)   r_err <= 1'b1;
    end
  end

  // Payload storage is not reset; slot state alone decides what is valid.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++)
      if (w_fill_en[b]) r_data[w_rob[b]] <= bank_rsp_data_i[b*DATA_W +: DATA_W];
  end

  assign alloc_ready_o   = !w_full;
  assign alloc_rob_num_o = w_tail_idx;
  assign rsp_valid_o     = w_rsp_valid;
  assign rsp_data_o      = r_data[w_head_idx];
  assign rsp_rob_num_o   = w_head_idx;
  assign rob_pop_o       = w_pop_fire;
  assign rob_count_o     = r_count;
  assign rob_err_o       = r_err;
endmodule

// File: tb/tb_xbar_rsp_rob.sv
// Directed bench for xbar_rsp_rob: per-cycle vector table plus hand sequences
// for full/wrap, backpressure and mid-flight reset.
module tb_xbar_rsp_rob;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         alloc_valid_i;
  logic         alloc_ready_o;
  logic [2:0]   alloc_rob_num_o;
  logic [3:0]   bank_rsp_valid_i;
  logic [7:0]   bank_rsp_ch_id_i;
  logic [11:0]  bank_rsp_rob_i;
  logic [511:0] bank_rsp_data_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [127:0] rsp_data_o;
  logic [2:0]   rsp_rob_num_o;
  logic         rob_pop_o;
  logic [3:0]   rob_count_o;
  logic         rob_err_o;

  int n_chk = 0;
  int n_fail = 0;

  xbar_rsp_rob #(.CH_ID(2'd0), .NUM_BANKS(4), .ROB_AW(3), .DATA_W(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_rob_num_o(alloc_rob_num_o),
    .bank_rsp_valid_i(bank_rsp_valid_i), .bank_rsp_ch_id_i(bank_rsp_ch_id_i),
    .bank_rsp_rob_i(bank_rsp_rob_i), .bank_rsp_data_i(bank_rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_rob_num_o(rsp_rob_num_o), .rob_pop_o(rob_pop_o), .rob_count_o(rob_count_o),
    .rob_err_o(rob_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Each bank's data identifies the bank and the slot it targets.
  function automatic logic [127:0] mkdata(input int b, input int r);
    return {4{24'hC0FFEE, 4'(b), 4'(r)}};
  endfunction

  always_comb begin
    bank_rsp_data_i = '0;
    for (int b = 0; b < 4; b++)
      bank_rsp_data_i[b*128 +: 128] = mkdata(b, int'(bank_rsp_rob_i[b*3 +: 3]));
  end

  typedef struct {
    logic rst, av, rdy;
    logic [3:0] bv;
    logic [7:0] ch;
    logic [11:0] rob;
    logic ck, ar;
    logic [2:0] anum;
    logic rv;
    logic [2:0] rnum;
    int rbank;
    logic pop;
    logic [3:0] cnt;
    logic err;
  } vec_t;

  function automatic vec_t V(input int rst, av, rdy, bv, ch, rob, ck, ar, anum, rv, rnum, rbank, pop, cnt, err);
    vec_t v;
    v.rst = rst[0]; v.av = av[0]; v.rdy = rdy[0]; v.bv = 4'(bv); v.ch = 8'(ch); v.rob = 12'(rob);
    v.ck = ck[0]; v.ar = ar[0]; v.anum = 3'(anum); v.rv = rv[0]; v.rnum = 3'(rnum);
    v.rbank = rbank; v.pop = pop[0]; v.cnt = 4'(cnt); v.err = err[0];
    return v;
  endfunction

  function automatic vec_t R();
    return V(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int rst, av, rdy, bv, ch, rob);
    rst_i = rst[0]; alloc_valid_i = av[0]; rsp_ready_i = rdy[0];
    bank_rsp_valid_i = 4'(bv); bank_rsp_ch_id_i = 8'(ch); bank_rsp_rob_i = 12'(rob);
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drv(1,0,0,0,0,0);
    tick();
    drv(0,0,0,0,0,0);
  endtask

  vec_t tbl[$];

  initial begin
    //            rst av rdy bv  ch  rob     ck ar an rv rn rb pop cnt err
    // T1 in-order
    tbl.push_back(V(0,1,0,0,0,0,        1,1,0,0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,1,0,0,0,0,1,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,2,0,0,0,0,2,0));
    tbl.push_back(V(0,0,1,1,0,'h000,    1,1,3,0,0,0,0,3,0));
    tbl.push_back(V(0,0,1,1,0,'h001,    1,1,3,1,0,0,1,3,0));
    tbl.push_back(V(0,0,1,1,0,'h002,    1,1,3,1,1,0,1,2,0));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,3,1,2,0,1,1,0));
    tbl.push_back(V(0,0,0,0,0,0,        1,1,3,0,0,0,0,0,0));
    // T2 reorder
    tbl.push_back(R());
    tbl.push_back(V(0,1,0,0,0,0,        1,1,0,0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,1,0,0,0,0,1,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,2,0,0,0,0,2,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,3,0,0,0,0,3,0));
    tbl.push_back(V(0,0,1,8,0,'h600,    1,1,4,0,0,0,0,4,0));
    tbl.push_back(V(0,0,1,2,0,'h008,    1,1,4,0,0,0,0,4,0));
    tbl.push_back(V(0,0,1,4,0,'h080,    1,1,4,0,0,0,0,4,0));
    tbl.push_back(V(0,0,1,1,0,'h000,    1,1,4,0,0,0,0,4,0));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,4,1,0,0,1,4,0));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,4,1,1,1,1,3,0));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,4,1,2,2,1,2,0));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,4,1,3,3,1,1,0));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,4,0,0,0,0,0,0));
    // T5a fill of a FREE slot
    tbl.push_back(R());
    tbl.push_back(V(0,0,0,1,0,'h005,    1,1,0,0,0,0,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,        1,1,0,0,0,0,0,0,1));
    // T5b double fill of slot2, then two distinct slots filled together
    tbl.push_back(R());
    tbl.push_back(V(0,1,0,0,0,0,        1,1,0,0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,1,0,0,0,0,1,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,2,0,0,0,0,2,0));
    tbl.push_back(V(0,0,0,1,0,'h002,    1,1,3,0,0,0,0,3,0));
    tbl.push_back(V(0,0,0,4,0,'h080,    1,1,3,0,0,0,0,3,0));
    tbl.push_back(V(0,0,0,3,0,'h008,    1,1,3,0,0,0,0,3,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,3,1,0,0,1,3,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,3,1,1,1,1,2,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,3,1,2,0,1,1,1));
    tbl.push_back(V(0,0,0,0,0,0,        1,1,3,0,0,0,0,0,1));
    // T5c foreign channel ignored, then banks 1 and 3 collide on slot4
    tbl.push_back(R());
    tbl.push_back(V(0,1,0,0,0,0,        1,1,0,0,0,0,0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,1,0,0,0,0,1,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,2,0,0,0,0,2,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,3,0,0,0,0,3,0));
    tbl.push_back(V(0,1,0,0,0,0,        1,1,4,0,0,0,0,4,0));
    tbl.push_back(V(0,0,0,1,1,'h000,    1,1,5,0,0,0,0,5,0));
    tbl.push_back(V(0,0,0,0,0,0,        1,1,5,0,0,0,0,5,0));
    tbl.push_back(V(0,0,0,'ha,0,'h820,  1,1,5,0,0,0,0,5,0));
    tbl.push_back(V(0,0,0,'hf,0,'h688,  1,1,5,0,0,0,0,5,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,5,1,0,0,1,5,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,5,1,1,1,1,4,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,5,1,2,2,1,3,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,5,1,3,3,1,2,1));
    tbl.push_back(V(0,0,1,0,0,0,        1,1,5,1,4,1,1,1,1));
    tbl.push_back(V(0,0,0,0,0,0,        1,1,5,0,0,0,0,0,1));

    drv(1,0,0,0,0,0);
    tick();
    do_reset();

    foreach (tbl[i]) begin
      drv(int'(tbl[i].rst), int'(tbl[i].av), int'(tbl[i].rdy), int'(tbl[i].bv), int'(tbl[i].ch), int'(tbl[i].rob));
      settle();
      if (tbl[i].ck) begin
        chk($sformatf("v%0d_ar", i),   32'(alloc_ready_o),   32'(tbl[i].ar));
        chk($sformatf("v%0d_anum", i), 32'(alloc_rob_num_o), 32'(tbl[i].anum));
        chk($sformatf("v%0d_rv", i),   32'(rsp_valid_o),     32'(tbl[i].rv));
        chk($sformatf("v%0d_pop", i),  32'(rob_pop_o),       32'(tbl[i].pop));
        chk($sformatf("v%0d_cnt", i),  32'(rob_count_o),     32'(tbl[i].cnt));
        chk($sformatf("v%0d_err", i),  32'(rob_err_o),       32'(tbl[i].err));
        if (tbl[i].rv) begin
          chk($sformatf("v%0d_rnum", i), 32'(rsp_rob_num_o), 32'(tbl[i].rnum));
          chkd($sformatf("v%0d_data", i), rsp_data_o, mkdata(tbl[i].rbank, int'(tbl[i].rnum)));
        end
      end
      tick();
    end

    // T3 full and wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(0,1,0,0,0,0);
      settle();
      chk($sformatf("t3_anum%0d", i), 32'(alloc_rob_num_o), 32'(i));
      chk($sformatf("t3_ar%0d", i), 32'(alloc_ready_o), 32'(1));
      tick();
    end
    drv(0,0,0,0,0,0);
    settle();
    chk("t3_full_ar", 32'(alloc_ready_o), 32'(0));
    chk("t3_full_cnt", 32'(rob_count_o), 32'(8));
    tick();
    drv(0,0,0,1,0,0);
    tick();
    drv(0,1,1,0,0,0);
    settle();
    chk("t3_pop_at_full", 32'(rob_pop_o), 32'(1));
    chk("t3_ar_at_pop", 32'(alloc_ready_o), 32'(0));
    tick();
    drv(0,1,0,0,0,0);
    settle();
    chk("t3_cnt_after_pop", 32'(rob_count_o), 32'(7));
    chk("t3_ar_wrap", 32'(alloc_ready_o), 32'(1));
    chk("t3_anum_wrap", 32'(alloc_rob_num_o), 32'(0));
    tick();
    drv(0,0,0,0,0,0);
    settle();
    chk("t3_cnt_refull", 32'(rob_count_o), 32'(8));
    chk("t3_ar_refull", 32'(alloc_ready_o), 32'(0));
    tick();

    // T4 backpressure on head slot1 (filled by bank2)
    drv(0,0,0,4,0,'h040);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) drv(0,0,0,1,0,'h003);
      else        drv(0,0,0,0,0,0);
      settle();
      chk($sformatf("t4_rv%0d", k), 32'(rsp_valid_o), 32'(1));
      chk($sformatf("t4_rnum%0d", k), 32'(rsp_rob_num_o), 32'(1));
      chkd($sformatf("t4_data%0d", k), rsp_data_o, mkdata(2, 1));
      chk($sformatf("t4_pop%0d", k), 32'(rob_pop_o), 32'(0));
      tick();
    end
    drv(0,0,1,0,0,0);
    settle();
    chk("t4_pop_ready", 32'(rob_pop_o), 32'(1));
    tick();
    drv(0,0,0,0,0,0);
    settle();
    chk("t4_rv_next", 32'(rsp_valid_o), 32'(0));
    chk("t4_cnt", 32'(rob_count_o), 32'(7));
    chk("t4_anum", 32'(alloc_rob_num_o), 32'(1));
    tick();

    // T6 reset mid-flight
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(0,1,0,0,0,0);
      tick();
    end
    drv(0,0,0,3,0,'h008);
    tick();
    drv(0,0,0,0,0,0);
    settle();
    chk("t6_pre_rv", 32'(rsp_valid_o), 32'(1));
    chk("t6_pre_cnt", 32'(rob_count_o), 32'(5));
    tick();
    drv(1,0,1,4,0,'h180);
    settle();
    chk("t6_pop_in_rst", 32'(rob_pop_o), 32'(0));
    tick();
    drv(0,0,0,0,0,0);
    settle();
    chk("t6_rv", 32'(rsp_valid_o), 32'(0));
    chk("t6_pop", 32'(rob_pop_o), 32'(0));
    chk("t6_cnt", 32'(rob_count_o), 32'(0));
    chk("t6_err", 32'(rob_err_o), 32'(0));
    chk("t6_ar", 32'(alloc_ready_o), 32'(1));
    chk("t6_anum", 32'(alloc_rob_num_o), 32'(0));
    tick();
    drv(0,1,0,0,0,0);
    settle();
    chk("t6_alloc_num", 32'(alloc_rob_num_o), 32'(0));
    tick();
    drv(0,0,0,2,0,'h008);
    settle();
    chk("t6_err_before", 32'(rob_err_o), 32'(0));
    tick();
    drv(0,0,0,0,0,0);
    settle();
    chk("t6_stale_err", 32'(rob_err_o), 32'(1));
    chk("t6_stale_rv", 32'(rsp_valid_o), 32'(0));
    chk("t6_stale_cnt", 32'(rob_count_o), 32'(1));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
